classify_ctrl: RTL and testbench
================================

Name: classify_ctrl

Overview:
- Sequencer between the final fully-connected layer and the shared 10-way signed argmax unit.
- Gathers the ten 32-bit class scores, which arrive one per beat, into a 320-bit vector.
- Pulses the argmax unit's enable, waits for its valid, and captures the one-hot winner.
- Presents the result (one-hot, binary digit, error flag) to the downstream consumer on a ready/valid handshake, and counts classified images.

Parameters:
- NUM_CLASSES, 10: number of class scores per image; fixed to match the argmax unit.
- DATA_W, 32: width of one signed score.
- TIMEOUT, 15: maximum cycles spent in WAIT before a result is forced with error=1.
- CNT_W, 16: width of the image counter.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  score beat valid.
- in_data  in  DATA_W  signed score; beat k (0-based) is class k.
- in_last  in  1  marks the final beat of an image.
- in_ready  out  1  controller accepts a beat.
- max_data  out  NUM_CLASSES*DATA_W  packed scores to the argmax unit; class k at bits [k*32 +: 32].
- max_enable  out  1  one-cycle start pulse to the argmax unit.
- max_out  in  NUM_CLASSES  one-hot winner from the argmax unit.
- max_valid  in  1  argmax done pulse.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_onehot  out  NUM_CLASSES  winning class, one-hot.
- res_digit  out  4  winning class, binary 0..9.
- res_error  out  1  framing error, timeout, or non-one-hot max_out.
- busy  out  1  state != COLLECT.
- img_count  out  CNT_W  results consumed since reset; wraps.

Behaviour:
- Reset values:
  - state=COLLECT, slot index=0.
  - max_data = all slots 32'h8000_0000.
  - max_enable=0, res_valid=0, res_onehot=0, res_digit=0, res_error=0, img_count=0, busy=0, internal error flag=0.
- Reset asserted mid-operation aborts the image. A max_valid that arrives after reset is ignored.
- COLLECT:
  - in_ready=1; a beat is accepted when in_valid & in_ready.
  - The accepted beat is written to slot[idx], then idx++.
  - in_last on beat idx<9: error flag set; slots idx+1..9 filled with 32'h8000_0000 (most negative); go to LAUNCH.
  - Beat idx==9: go to LAUNCH; if in_last=0 on this beat, error flag set. The following beats start the next image.
  - Slots are cleared to 32'h8000_0000 on entry to COLLECT.
- LAUNCH:
  - in_ready=0; max_enable=1 for exactly one cycle; max_data stable from this cycle until the result is captured.
  - Next state WAIT; timeout counter cleared.
- WAIT:
  - Counter increments each cycle.
  - On max_valid: capture max_out into res_onehot and encode res_digit as the index of the set bit.
    - If max_out is not exactly one-hot: res_onehot=0, res_digit=0, error=1.
  - If the counter reaches TIMEOUT without max_valid: res_onehot=0, res_digit=0, error=1.
  - Either way, go to HOLD with res_valid=1 on the next cycle.
  - Nominal argmax latency is 11 cycles from enable, so TIMEOUT=15 gives margin.
  - max_valid and timeout in the same cycle: max_valid wins.
- HOLD:
  - res_valid=1; res_onehot, res_digit and res_error held stable until res_ready.
  - On res_valid & res_ready: img_count++ (wraps at 2^CNT_W); error flag cleared; go to COLLECT, with in_ready=1 in the next cycle.
  - No combinational path from res_ready to in_ready.
- max_valid outside WAIT is ignored.
- Throughput: 10 + 1 + 11 + 1 = 23 cycles minimum per image.

Decomposition:
- Shared package:
  - NUM_CLASSES, DATA_W.
  - Score-floor constant SCORE_MIN = 32'h8000_0000.
  - State encoding COLLECT/LAUNCH/WAIT/HOLD (2-bit).
  - onehot-to-index function with a valid-one-hot check.
- One natural sub-module: score_packer. It owns the slot registers, idx, padding and clear, and drives max_data. The controller FSM stays in classify_ctrl.
- The argmax unit is instantiated alongside, not inside.

Test Plan:
- Nominal image: scores class k = k*100, class 7 = 5000, in_last on beat 9, res_ready=1 → max_enable one cycle after beat 9; res_onehot=10'b0010000000, res_digit=7, res_error=0, img_count=1.
- Negative scores: all scores -1000 except class 0 = -5, class 9 = -5 → res_digit=0 (first maximum wins), res_onehot=10'b0000000001.
- Early in_last on beat 4 with class 2 = 3 as the maximum → slots 5..9 equal 32'h8000_0000 on max_data; res_digit=2, res_error=1.
- Backpressure: res_ready=0 for 20 cycles after res_valid → res_* stable, in_ready=0, img_count unchanged; res_ready=1 → img_count++ and in_ready=1 on the next cycle.
- Timeout: argmax model never asserts max_valid → res_valid 16 cycles after max_enable, res_onehot=0, res_error=1. A stray max_valid injected during COLLECT is ignored.
- Reset mid-WAIT, then a clean image with class 3 maximum → all outputs at reset values; the late max_valid from the aborted image is ignored; the next result has res_digit=3, res_error=0, img_count=1.

Source files
------------

// File: rtl/classify_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : classify_ctrl_pkg
//  Description : Shared definitions for the classifier sequencer: class count,
//                score width, score floor, controller state encoding and a
//                one-hot to index helper with a one-hot validity check.
//  Revision    : 1.0 - initial release
// ============================================================================
package classify_ctrl_pkg;

    localparam int NUM_CLASSES = 10;
    localparam int DATA_W      = 32;
    localparam int IDX_W       = 4;

    // Most negative signed score; padding for slots that never received a beat.
    localparam logic [DATA_W-1:0] SCORE_MIN = 32'h8000_0000;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_LAUNCH  = 2'd1,
        S_WAIT    = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    typedef struct packed {
        logic             ok;   // exactly one bit set
        logic [IDX_W-1:0] idx;  // position of the set bit (meaningful when ok)
    } onehot_idx_t;

    function automatic onehot_idx_t onehot_to_index(input logic [NUM_CLASSES-1:0] vec);
        onehot_idx_t r;
        int          ones;
        r.ok  = 1'b0;
        r.idx = '0;
        ones  = 0;
        for (int i = 0; i < NUM_CLASSES; i++) begin
            if (vec[i]) begin
                ones  = ones + 1;
                r.idx = IDX_W'(i);
            end
        end
        r.ok = (ones == 1);
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/classify_ctrl_score_packer.sv
`default_nettype none
// ============================================================================
//  Module      : score_packer
//  Description : Gathers one signed score per accepted beat into the packed
//                score vector for the argmax unit. Pads unfilled slots with
//                SCORE_MIN on an early last beat, and clears all slots when the
//                controller returns to collection.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                beat_accept       - a score beat is taken this cycle
//                beat_data/last    - score value and end-of-image marker
//                clear             - reload all slots with SCORE_MIN, idx=0
//                frame_done        - this accepted beat closes the image
//                frame_err         - last marker does not match the final slot
//                max_data          - packed scores, class k at [k*32 +: 32]
//  Revision    : 1.0 - initial release
// ============================================================================
module score_packer
    import classify_ctrl_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          beat_accept,
    input  logic [DATA_W-1:0]             beat_data,
    input  logic                          beat_last,
    input  logic                          clear,
    output logic                          frame_done,
    output logic                          frame_err,
    output logic [NUM_CLASSES*DATA_W-1:0] max_data
);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    logic [DATA_W-1:0] r_slot [NUM_CLASSES];
    logic [IDX_W-1:0]  r_idx;
    logic              w_at_last;

    assign w_at_last  = (r_idx == C_LAST_IDX);
    assign frame_done = beat_accept & (beat_last | w_at_last);
    // Error when last arrives early, or when the tenth beat lacks it.
    assign frame_err  = beat_accept & (beat_last ^ w_at_last);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_idx <= '0;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                r_slot[k] <= SCORE_MIN;
            end
        end else if (beat_accept) begin
            r_idx <= frame_done ? '0 : r_idx + 1'b1;
            for (int k = 0; k < NUM_CLASSES; k++) begin
                if (IDX_W'(k) == r_idx) begin
                    r_slot[k] <= beat_data;
                end else if (beat_last && (IDX_W'(k) > r_idx)) begin
                    r_slot[k] <= SCORE_MIN;
                end
            end
        end
    end

    generate
        for (genvar k = 0; k < NUM_CLASSES; k++) begin : g_pack
            assign max_data[k*DATA_W +: DATA_W] = r_slot[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/classify_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : classify_ctrl
//  Description : Sequencer between the last FC layer and the shared argmax
//                unit. Collects ten scores, launches the argmax, waits for its
//                answer (with timeout), and holds the classification for the
//                consumer on a ready/valid handshake. Counts consumed results.
//  Ports       : clk, rst                 - clock, synchronous active-high reset
//                in_valid/in_data/in_last - score beats, in_ready back-pressure
//                max_data/max_enable      - packed scores and start pulse
//                max_out/max_valid        - one-hot winner and done pulse
//                res_valid/res_ready      - result handshake
//                res_onehot/digit/error   - classification result
//                busy, img_count          - status
//  Revision    : 1.0 - initial release
// ============================================================================
module classify_ctrl
    import classify_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 16
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_last,
    output logic                          in_ready,
    output logic [NUM_CLASSES*DATA_W-1:0] max_data,
    output logic                          max_enable,
    input  logic [NUM_CLASSES-1:0]        max_out,
    input  logic                          max_valid,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [NUM_CLASSES-1:0]        res_onehot,
    output logic [3:0]                    res_digit,
    output logic                          res_error,
    output logic                          busy,
    output logic [CNT_W-1:0]              img_count
);

    localparam int              TO_W       = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] C_TO_LAST  = TO_W'(TIMEOUT - 1);

    state_t                   r_state;
    logic [TO_W-1:0]          r_tcnt;
    logic                     r_err;
    logic                     r_in_ready;
    logic                     r_busy;
    logic                     r_max_enable;
    logic                     r_res_valid;
    logic [NUM_CLASSES-1:0]   r_res_onehot;
    logic [3:0]               r_res_digit;
    logic                     r_res_error;
    logic [CNT_W-1:0]         r_img_count;

    logic                     w_accept;
    logic                     w_handshake;
    logic                     w_frame_done;
    logic                     w_frame_err;
    onehot_idx_t              w_oh;

    assign w_accept    = in_valid & r_in_ready;
    assign w_handshake = (r_state == S_HOLD) & r_res_valid & res_ready;
    assign w_oh        = onehot_to_index(max_out);

    score_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .beat_accept (w_accept),
        .beat_data   (in_data),
        .beat_last   (in_last),
        .clear       (w_handshake),
        .frame_done  (w_frame_done),
        .frame_err   (w_frame_err),
        .max_data    (max_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_COLLECT;
            r_tcnt       <= '0;
            r_err        <= 1'b0;
            r_in_ready   <= 1'b1;
            r_busy       <= 1'b0;
            r_max_enable <= 1'b0;
            r_res_valid  <= 1'b0;
            r_res_onehot <= '0;
            r_res_digit  <= '0;
            r_res_error  <= 1'b0;
            r_img_count  <= '0;
        end else begin
            r_max_enable <= 1'b0;
            case (r_state)
                S_COLLECT: begin
                    if (w_frame_done) begin
                        r_state      <= S_LAUNCH;
                        r_in_ready   <= 1'b0;
                        r_busy       <= 1'b1;
                        r_max_enable <= 1'b1;
                        if (w_frame_err) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_LAUNCH: begin
                    r_state <= S_WAIT;
                    r_tcnt  <= '0;
                end
                S_WAIT: begin
                    r_tcnt <= r_tcnt + 1'b1;
                    // A real answer takes priority over a simultaneous timeout.
                    if (max_valid) begin
                        r_res_onehot <= w_oh.ok ? max_out : '0;
                        r_res_digit  <= w_oh.ok ? w_oh.idx : '0;
                        r_res_error  <= r_err | ~w_oh.ok;
                        r_res_valid  <= 1'b1;
                        r_state      <= S_HOLD;
                    end else if (r_tcnt == C_TO_LAST) begin
                        r_res_onehot <= '0;
                        r_res_digit  <= '0;
                        r_res_error  <= 1'b1;
                        r_res_valid  <= 1'b1;
                        r_state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        r_img_count <= r_img_count + 1'b1;
                        r_err       <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_COLLECT;
                    end
                end
                default: begin
                    r_state <= S_COLLECT;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign busy       = r_busy;
    assign max_enable = r_max_enable;
    assign res_valid  = r_res_valid;
    assign res_onehot = r_res_onehot;
    assign res_digit  = r_res_digit;
    assign res_error  = r_res_error;
    assign img_count  = r_img_count;

endmodule
`default_nettype wire

// File: tb/tb_classify_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_classify_ctrl
//  Description : Self-checking bench for classify_ctrl with an argmax unit
//                model, a result scoreboard and randomized images.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_classify_ctrl;
    import classify_ctrl_pkg::*;

    localparam int VW   = NUM_CLASSES * DATA_W;
    localparam int LAT  = 11;
    localparam int SMIN = 32'sh8000_0000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid, in_last, in_ready;
    logic [DATA_W-1:0]      in_data;
    logic [VW-1:0]          max_data;
    logic                   max_enable, max_valid;
    logic [NUM_CLASSES-1:0] max_out;
    logic                   res_valid, res_ready;
    logic [NUM_CLASSES-1:0] res_onehot;
    logic [3:0]             res_digit;
    logic                   res_error, busy;
    logic [15:0]            img_count;

    logic                   am_valid = 1'b0;
    logic                   stray_valid = 1'b0;
    logic [NUM_CLASSES-1:0] am_out = '0;

    assign max_valid = am_valid | stray_valid;
    assign max_out   = stray_valid ? NUM_CLASSES'(1) : am_out;

    typedef struct {
        logic [NUM_CLASSES-1:0] oh;
        logic [3:0]             dig;
        logic                   err;
    } res_t;

    res_t          exp_q[$];
    logic [VW-1:0] vec_q[$];
    int            mode_q[$];   // 0 normal, 1 silent, 2 zero out, 3 two bits

    int checks = 0;
    int errors = 0;
    bit rr_random = 1'b0;
    bit rr_force  = 1'b1;

    classify_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .max_data   (max_data),
        .max_enable (max_enable),
        .max_out    (max_out),
        .max_valid  (max_valid),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_onehot (res_onehot),
        .res_digit  (res_digit),
        .res_error  (res_error),
        .busy       (busy),
        .img_count  (img_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_res_valid"},  res_valid, 0);
        check({tag, "_res_onehot"}, res_onehot, 0);
        check({tag, "_res_digit"},  res_digit, 0);
        check({tag, "_res_error"},  res_error, 0);
        check({tag, "_img_count"},  img_count, 0);
        check({tag, "_busy"},       busy, 0);
        check({tag, "_max_enable"}, max_enable, 0);
        check({tag, "_in_ready"},   in_ready, 1);
        check({tag, "_max_data"},   max_data, {NUM_CLASSES{SCORE_MIN}});
    endtask

    // res_ready driver
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            res_ready = rr_random ? ($urandom_range(0, 2) != 0) : rr_force;
        end
    end

    // Argmax unit model: first maximum wins, answers LAT cycles after enable.
    initial begin
        logic [VW-1:0]          ev;
        logic [NUM_CLASSES-1:0] oh;
        int                     md, w;
        forever begin
            @(negedge clk);
            if (!rst && max_enable) begin
                if (vec_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_enable: got max_enable=1 expected no launch");
                    ev = max_data; md = 0;
                end else begin
                    ev = vec_q.pop_front();
                    md = mode_q.pop_front();
                end
                check("max_data", max_data, ev);
                w = 0;
                for (int k = 1; k < NUM_CLASSES; k++) begin
                    if ($signed(max_data[k*DATA_W +: DATA_W]) > $signed(max_data[w*DATA_W +: DATA_W])) w = k;
                end
                oh = NUM_CLASSES'(1) << w;
                @(negedge clk);
                check("max_enable_pulse", max_enable, 0);
                if (md != 1) begin
                    repeat (LAT - 1) @(posedge clk);
                    #1;
                    am_out   = (md == 0) ? oh :
                               (md == 2) ? '0 : (oh | ((w == 0) ? NUM_CLASSES'(2) : NUM_CLASSES'(1)));
                    am_valid = 1'b1;
                    @(posedge clk); #1;
                    am_valid = 1'b0;
                    am_out   = '0;
                end
            end
        end
    end

    // Result monitor / scoreboard
    initial begin
        int   mcnt;
        bit   prev_hold;
        res_t held, r;
        mcnt = 0; prev_hold = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mcnt = 0; prev_hold = 0;
            end else begin
                if (prev_hold) begin
                    check("hold_onehot", res_onehot, held.oh);
                    check("hold_digit",  res_digit,  held.dig);
                    check("hold_error",  res_error,  held.err);
                    check("hold_in_ready", in_ready, 0);
                    check("hold_img_count", img_count, mcnt);
                end
                if (res_valid) begin
                    check("busy_with_result", busy, 1);
                    if (res_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++; errors++;
                            $display("FAIL unexpected_result: got res_valid=1 expected none pending");
                        end else begin
                            r = exp_q.pop_front();
                            check("res_onehot", res_onehot, r.oh);
                            check("res_digit",  res_digit,  r.dig);
                            check("res_error",  res_error,  r.err);
                            check("img_count",  img_count,  mcnt);
                        end
                        mcnt = (mcnt + 1) & 16'hffff;
                        prev_hold = 0;
                    end else begin
                        prev_hold = 1;
                        held.oh = res_onehot; held.dig = res_digit; held.err = res_error;
                    end
                end else begin
                    prev_hold = 0;
                end
            end
        end
    end

    task automatic wait_accept();
        int t = 0;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                return;
            end
            t++;
            if (t > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got in_ready=0 for 200 cycles expected 1");
                @(posedge clk); #1;
                return;
            end
        end
    endtask

    // Pushes the expected launch vector and result, then drives the beats.
    // Returns one step after the final beat is taken (the launch cycle).
    task automatic send_image(input int sc[NUM_CLASSES], input int n, input bit last_ok,
                              input int mode, input bit gaps, input bit stray);
        logic [VW-1:0] pv;
        res_t          r;
        int            v, vbest, best;
        bit            ferr;
        ferr = (n < NUM_CLASSES) || !last_ok;
        best = 0; vbest = 0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            v = (k < n) ? sc[k] : SMIN;
            pv[k*DATA_W +: DATA_W] = v;
            if (k == 0 || v > vbest) begin
                vbest = v; best = k;
            end
        end
        if (mode == 0) begin
            r.oh = NUM_CLASSES'(1) << best; r.dig = 4'(best); r.err = ferr;
        end else begin
            r.oh = '0; r.dig = '0; r.err = 1'b1;
        end
        vec_q.push_back(pv);
        mode_q.push_back(mode);
        exp_q.push_back(r);
        for (int b = 0; b < n; b++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    in_valid = 1'b0; @(posedge clk); #1;
                end
            end
            if (stray && b == 5) begin
                in_valid = 1'b0; stray_valid = 1'b1;
                @(posedge clk); #1;
                stray_valid = 1'b0;
            end
            in_valid = 1'b1;
            in_data  = sc[b];
            in_last  = (b == n - 1) ? ((n < NUM_CLASSES) ? 1'b1 : last_ok) : 1'b0;
            wait_accept();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic lat_to_valid(input string nm, input int exp);
        int n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!res_valid && n < 60);
        check(nm, n, exp);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 1000) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 1000) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d results pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        int sc[NUM_CLASSES];
        int n, md;
        bit lok;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        repeat (3) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        check_reset("reset");
        @(posedge clk); #1;

        // Nominal image, class 7 wins
        for (int k = 0; k < NUM_CLASSES; k++) sc[k] = k * 100;
        sc[7] = 5000;
        send_image(sc, 10, 1, 0, 0, 0);
        check("enable_after_beat9", max_enable, 1);
        lat_to_valid("nominal_latency", 12);
        @(posedge clk); #1;
        check("nominal_img_count", img_count, 1);
        check("nominal_in_ready", in_ready, 1);

        // Negative scores with tie: first maximum wins
        for (int k = 0; k < NUM_CLASSES; k++) sc[k] = -1000;
        sc[0] = -5; sc[9] = -5;
        send_image(sc, 10, 1, 0, 0, 0);
        wait_idle();

        // Early last on beat 4, class 2 wins, padding checked on max_data
        sc[0] = -7; sc[1] = -9; sc[2] = 3; sc[3] = -1; sc[4] = 0;
        send_image(sc, 5, 1, 0, 0, 0);
        wait_idle();

        // Backpressure for 20 cycles
        rr_force = 1'b0;
        for (int k = 0; k < NUM_CLASSES; k++) sc[k] = k;
        sc[4] = 77;
        send_image(sc, 10, 1, 0, 0, 0);
        lat_to_valid("bp_latency", 12);
        repeat (20) begin
            @(negedge clk);
            check("bp_in_ready", in_ready, 0);
            check("bp_img_count", img_count, 3);
            check("bp_res_valid", res_valid, 1);
        end
        @(posedge clk); #1;
        rr_force = 1'b1;
        begin
            int t = 0;
            do begin
                @(negedge clk); t++;
            end while (!(res_valid && res_ready) && t < 10);
        end
        @(posedge clk); #1;
        check("bp_release_in_ready", in_ready, 1);
        check("bp_release_img_count", img_count, 4);

        // Timeout with a stray max_valid during collection
        for (int k = 0; k < NUM_CLASSES; k++) sc[k] = 10 - k;
        send_image(sc, 10, 1, 1, 0, 1);
        lat_to_valid("timeout_latency", 16);
        wait_idle();

        // Reset in the middle of WAIT, then a clean image
        for (int k = 0; k < NUM_CLASSES; k++) sc[k] = 0;
        sc[5] = 9;
        send_image(sc, 10, 1, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1; rst = 1'b1;
        exp_q.delete(); vec_q.delete(); mode_q.delete();
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
        @(negedge clk);
        check_reset("midreset");
        @(posedge clk); #1;
        for (int k = 0; k < NUM_CLASSES; k++) sc[k] = -k;
        sc[3] = 400;
        send_image(sc, 10, 1, 0, 0, 0);
        wait_idle();
        check("post_reset_img_count", img_count, 1);

        // Randomized images
        rr_random = 1'b1;
        for (int i = 0; i < 30; i++) begin
            md = $urandom_range(0, 9);
            md = (md < 7) ? 0 : md - 6;
            n   = ($urandom_range(0, 6) == 0) ? int'($urandom_range(1, 9)) : 10;
            lok = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < NUM_CLASSES; k++) begin
                sc[k] = ($urandom_range(0, 1) == 0) ? (int'($urandom_range(0, 20)) - 10) : int'($urandom);
            end
            send_image(sc, n, lok, md, 1, 0);
        end
        wait_idle();
        rr_random = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
